l2_cache_dir_ctrl: RTL

//  Parametrised set-associative L2 tag/state directory with MESI coherence, true-LRU replacement and

---
 rtl/l2_cache_dir_ctrl_if.sv | 30 +++
 rtl/l2_cache_dir_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_dir_ctrl_if.sv
// L1-request / shared-bus handshake bundle for the L2 directory controller.
// The requester drives the master side; the directory is the slave.
// Parameters must match the directory's ADDR_W and $clog2(WAYS).
interface l2_cache_dir_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int AGE_W  = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic              bus_shared;
    logic              resp_valid;
    logic              resp_ready;
    logic              resp_hit;
    logic [AGE_W-1:0]  resp_way;
    logic [2:0]        resp_bus_op;
    logic [1:0]        resp_snoop;
    logic [1:0]        resp_mesi;

    modport slave (
        input  req_valid, req_op, req_addr, bus_shared, resp_ready,
        output req_ready, resp_valid, resp_hit, resp_way, resp_bus_op, resp_snoop, resp_mesi
    );

    modport master (
        output req_valid, req_op, req_addr, bus_shared, resp_ready,
        input  req_ready, resp_valid, resp_hit, resp_way, resp_bus_op, resp_snoop, resp_mesi
    );
endinterface

// File: rtl/l2_cache_dir_ctrl.sv
// Set-associative L2 tag/MESI directory with true-LRU replacement and snoop handling.
// Latency: response 3 cycles after accept (LOOKUP, UPDATE, RESP); CLR sweep answers after SETS+1.
// Backpressure: one request in flight; req_ready only in IDLE; response held until resp_ready.
module l2_cache_dir_ctrl #(
    parameter int  ADDR_W      = 32,
    parameter int  OFFSET_BITS = 6,
    parameter int  SETS        = 64,
    parameter int  WAYS        = 8,
    parameter int  CNT_W       = 32,
    localparam int INDEX_BITS  = $clog2(SETS),
    localparam int AGE_W       = $clog2(WAYS),
    localparam int TAG_BITS    = ADDR_W - OFFSET_BITS - INDEX_BITS
) (
    input  logic               clk,
    input  logic               rst_n,
    l2_cache_dir_ctrl_if.slave bus,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    localparam logic [2:0] OP_RD = 3'd0, OP_WR = 3'd1, OP_SNP_RD = 3'd2, OP_SNP_RDX = 3'd3, OP_CLR = 3'd4;
    localparam logic [2:0] BUS_NONE = 3'd0, BUS_READ = 3'd1, BUS_RFO = 3'd2, BUS_INV = 3'd3,
                           BUS_WB_READ = 3'd4, BUS_WB_RFO = 3'd5, BUS_WB = 3'd6;
    localparam logic [1:0] SNP_NOHIT = 2'd0, SNP_HIT = 2'd1, SNP_HITM = 2'd2;
    localparam logic [1:0] ST_I = 2'd0, ST_S = 2'd1, ST_E = 2'd2, ST_M = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_UPDATE, S_RESP, S_SWEEP} state_t;

    state_t                state_q;
    logic                  req_ready_q, resp_valid_q, resp_hit_q;
    logic [AGE_W-1:0]      resp_way_q;
    logic [2:0]            resp_bus_op_q;
    logic [1:0]            resp_snoop_q, resp_mesi_q;
    logic [2:0]            req_op_q;
    logic [INDEX_BITS-1:0] req_set_q, sweep_q;
    logic [TAG_BITS-1:0]   req_tag_q;
    logic                  hit_q, shared_q;
    logic [AGE_W-1:0]      way_q;
    logic [CNT_W-1:0]      hit_cnt_q, miss_cnt_q;

    logic [TAG_BITS-1:0]   tag_arr_q  [SETS][WAYS];
    logic [1:0]            mesi_arr_q [SETS][WAYS];
    logic [AGE_W-1:0]      age_arr_q  [SETS][WAYS];

    logic                  accept;
    logic [WAYS-1:0]       match_d;
    logic                  hit_d, inv_found;
    logic [AGE_W-1:0]      hit_way_d, inv_way, lru_way, way_d;
    logic [1:0]            cur_mesi, new_mesi_d, mesi_rsp_d, snoop_d;
    logic [AGE_W-1:0]      cur_age, way_rsp_d;
    logic [2:0]            bus_op_d;
    logic                  hit_rsp_d, line_wr_d, fill_d, touch_d, cnt_hit_d, cnt_miss_d;
    logic                  unused_offset;

    assign accept        = bus.req_valid && req_ready_q;
    assign unused_offset = ^bus.req_addr[OFFSET_BITS-1:0];

    // Parallel tag compare; victim is the lowest invalid way, otherwise the oldest way.
    always_comb begin
        match_d   = '0;
        hit_d     = 1'b0;
        hit_way_d = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        lru_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match_d[w] = (mesi_arr_q[req_set_q][w] != ST_I) && (tag_arr_q[req_set_q][w] == req_tag_q);
            if (match_d[w]) begin
                hit_d     = 1'b1;
                hit_way_d = AGE_W'(w);
            end
            if (mesi_arr_q[req_set_q][w] == ST_I) begin
                inv_found = 1'b1;
                inv_way   = AGE_W'(w);
            end
            if (age_arr_q[req_set_q][w] == AGE_W'(WAYS - 1)) lru_way = AGE_W'(w);
        end
        way_d = hit_d ? hit_way_d : (inv_found ? inv_way : lru_way);
    end

    // MESI transition, bus operation and bookkeeping decisions for the UPDATE cycle.
    always_comb begin
        cur_mesi   = mesi_arr_q[req_set_q][way_q];
        cur_age    = age_arr_q[req_set_q][way_q];
        new_mesi_d = cur_mesi;
        bus_op_d   = BUS_NONE;
        snoop_d    = SNP_NOHIT;
        hit_rsp_d  = hit_q;
        way_rsp_d  = way_q;
        line_wr_d  = 1'b0;
        fill_d     = 1'b0;
        touch_d    = 1'b0;
        cnt_hit_d  = 1'b0;
        cnt_miss_d = 1'b0;
        case (req_op_q)
            OP_RD, OP_WR: begin
                line_wr_d  = 1'b1;
                touch_d    = 1'b1;
                fill_d     = !hit_q;
                cnt_hit_d  = hit_q;
                cnt_miss_d = !hit_q;
                if (req_op_q == OP_RD) begin
                    if (!hit_q) begin
                        new_mesi_d = shared_q ? ST_S : ST_E;
                        bus_op_d   = (cur_mesi == ST_M) ? BUS_WB_READ : BUS_READ;
                    end
                end else begin
                    new_mesi_d = ST_M;
                    if (hit_q) bus_op_d = (cur_mesi == ST_S) ? BUS_INV : BUS_NONE;
                    else       bus_op_d = (cur_mesi == ST_M) ? BUS_WB_RFO : BUS_RFO;
                end
            end
            OP_SNP_RD, OP_SNP_RDX: begin
                if (hit_q) begin
                    line_wr_d  = 1'b1;
                    snoop_d    = (cur_mesi == ST_M) ? SNP_HITM : SNP_HIT;
                    bus_op_d   = (cur_mesi == ST_M) ? BUS_WB : BUS_NONE;
                    new_mesi_d = (req_op_q == OP_SNP_RD) ? ST_S : ST_I;
                end else begin
                    new_mesi_d = ST_I;
                    way_rsp_d  = '0;
                end
            end
            default: begin
                hit_rsp_d  = 1'b0;
                new_mesi_d = ST_I;
                way_rsp_d  = '0;
            end
        endcase
        mesi_rsp_d = new_mesi_d;
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_hit_q    <= 1'b0;
            resp_way_q    <= '0;
            resp_bus_op_q <= BUS_NONE;
            resp_snoop_q  <= SNP_NOHIT;
            resp_mesi_q   <= ST_I;
            req_op_q      <= '0;
            req_set_q     <= '0;
            req_tag_q     <= '0;
            hit_q         <= 1'b0;
            way_q         <= '0;
            shared_q      <= 1'b0;
            sweep_q       <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    req_ready_q <= 1'b0;
                    req_op_q    <= bus.req_op;
                    req_set_q   <= bus.req_addr[OFFSET_BITS +: INDEX_BITS];
                    req_tag_q   <= bus.req_addr[ADDR_W-1 -: TAG_BITS];
                    sweep_q     <= '0;
                    state_q     <= (bus.req_op == OP_CLR) ? S_SWEEP : S_LOOKUP;
                end
                S_LOOKUP: begin
                    hit_q    <= hit_d;
                    way_q    <= way_d;
                    shared_q <= bus.bus_shared;
                    state_q  <= S_UPDATE;
                end
                S_UPDATE: begin
                    resp_valid_q  <= 1'b1;
                    resp_hit_q    <= hit_rsp_d;
                    resp_way_q    <= way_rsp_d;
                    resp_bus_op_q <= bus_op_d;
                    resp_snoop_q  <= snoop_d;
                    resp_mesi_q   <= mesi_rsp_d;
                    state_q       <= S_RESP;
                end
                S_SWEEP: begin
                    if (sweep_q == INDEX_BITS'(SETS - 1)) begin
                        resp_valid_q  <= 1'b1;
                        resp_hit_q    <= 1'b0;
                        resp_way_q    <= '0;
                        resp_bus_op_q <= BUS_NONE;
                        resp_snoop_q  <= SNP_NOHIT;
                        resp_mesi_q   <= ST_I;
                        state_q       <= S_RESP;
                    end else begin
                        sweep_q <= sweep_q + 1'b1;
                    end
                end
                S_RESP: if (bus.resp_ready) begin
                    resp_valid_q <= 1'b0;
                    req_ready_q  <= 1'b1;
                    state_q      <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Directory arrays: sweep clears one set per cycle, UPDATE writes the selected line and ages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    tag_arr_q[s][w]  <= '0;
                    mesi_arr_q[s][w] <= ST_I;
                    age_arr_q[s][w]  <= AGE_W'(w);
                end
            end
        end else if (state_q == S_SWEEP) begin
            for (int w = 0; w < WAYS; w++) begin
                mesi_arr_q[sweep_q][w] <= ST_I;
                age_arr_q[sweep_q][w]  <= AGE_W'(w);
            end
        end else if (state_q == S_UPDATE) begin
            if (fill_d)    tag_arr_q[req_set_q][way_q]  <= req_tag_q;
            if (line_wr_d) mesi_arr_q[req_set_q][way_q] <= new_mesi_d;
            if (touch_d) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (age_arr_q[req_set_q][w] < cur_age)
                        age_arr_q[req_set_q][w] <= age_arr_q[req_set_q][w] + AGE_W'(1);
                end
                age_arr_q[req_set_q][way_q] <= '0;
            end
        end
    end

    // Saturating hit/miss statistics; CLR zeroes them on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_IDLE && accept && bus.req_op == OP_CLR) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_UPDATE) begin
            if (cnt_hit_d && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (cnt_miss_d && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

    // A tag may be resident in at most one way of a set.
    a_single_match: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == S_LOOKUP) |-> $onehot0(match_d));

    assign bus.req_ready   = req_ready_q;
    assign bus.resp_valid  = resp_valid_q;
    assign bus.resp_hit    = resp_hit_q;
    assign bus.resp_way    = resp_way_q;
    assign bus.resp_bus_op = resp_bus_op_q;
    assign bus.resp_snoop  = resp_snoop_q;
    assign bus.resp_mesi   = resp_mesi_q;
    assign hit_cnt         = hit_cnt_q;
    assign miss_cnt        = miss_cnt_q;
endmodule
